// File: rtl/arb_pkg.sv
// Shared encodings for the arbitrage order sequencer: action codes, exchange
// codes, FSM state encoding and order record layout.
package arb_pkg;

   // Per-exchange action codes from the decision stage
   localparam logic [1:0] ACT_HOLD = 2'b00;
   localparam logic [1:0] ACT_BUY  = 2'b01;
   localparam logic [1:0] ACT_SELL = 2'b10;
   localparam logic [1:0] ACT_NONE = 2'b11;

   // Exchange codes as carried in the order record
   localparam logic [1:0] EX_A = 2'd0;
   localparam logic [1:0] EX_B = 2'd1;
   localparam logic [1:0] EX_C = 2'd2;

   // Sequencer FSM states
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_QUALIFY  = 2'd1;
   localparam logic [1:0] ST_EMIT     = 2'd2;
   localparam logic [1:0] ST_COOLDOWN = 2'd3;

   // Order record layout: {seq, buy_ex, sell_ex, spread}
   localparam int unsigned SEQ_W      = 8;
   localparam int unsigned EX_W       = 2;
   localparam int unsigned SPREAD_W   = 16;
   localparam int unsigned ORDER_W    = SEQ_W + 2 * EX_W + SPREAD_W;
   localparam int unsigned SPREAD_LSB = 0;
   localparam int unsigned SELL_LSB   = SPREAD_LSB + SPREAD_W;
   localparam int unsigned BUY_LSB    = SELL_LSB + EX_W;
   localparam int unsigned SEQ_LSB    = BUY_LSB + EX_W;

   typedef struct packed {
      logic            ok;
      logic [EX_W-1:0] buy_ex;
      logic [EX_W-1:0] sell_ex;
   } pattern_t;

   // Decode {c, b, a} actions; ok only for exactly one BUY, one SELL, one HOLD
   function automatic pattern_t decode_pattern(input logic [5:0] acts);
      pattern_t   p;
      logic [1:0] n_buy;
      logic [1:0] n_sell;
      logic [1:0] n_hold;
      p      = '0;
      n_buy  = '0;
      n_sell = '0;
      n_hold = '0;
      for (int i = 0; i < 3; i++) begin
         case (acts[2*i +: 2])
            ACT_BUY: begin
               n_buy    = n_buy + 2'd1;
               p.buy_ex = 2'(i);
            end
            ACT_SELL: begin
               n_sell    = n_sell + 2'd1;
               p.sell_ex = 2'(i);
            end
            ACT_HOLD: n_hold = n_hold + 2'd1;
            default: ;
         endcase
      end
      p.ok = (n_buy == 2'd1) && (n_sell == 2'd1) && (n_hold == 2'd1);
      return p;
   endfunction

endpackage

// File: rtl/order_fifo.sv
// First-word-fall-through FIFO holding queued order records.
// Push while full is accepted only when a pop happens in the same cycle.
module order_fifo #(
   parameter int unsigned WIDTH = 28,
   parameter int unsigned DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_data
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   // Head is forced to zero while empty so the output is defined out of reset
   assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   // Pointer update; reset discards all queued entries
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // Storage write; contents are don't-care until the pointers cover them
   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/arb_order_sequencer.sv
// Arbitrage order sequencer: qualifies a stable BUY/SELL/HOLD pattern, builds a
// sequenced order record with the captured spread and queues it toward the
// consumer, with a cooldown between issues.
// Build option: define ORDER_SPREAD_CHECK_EN to discard orders whose spread is
// below MIN_SPREAD.
module arb_order_sequencer
   import arb_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES   = 4,
   parameter int unsigned COOLDOWN_CYCLES = 1000,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter logic [15:0] MIN_SPREAD      = 16'd1
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_enable,
   input  logic [15:0]  i_price_a,
   input  logic [15:0]  i_price_b,
   input  logic [15:0]  i_price_c,
   input  logic [1:0]   i_action_a,
   input  logic [1:0]   i_action_b,
   input  logic [1:0]   i_action_c,
   output logic         o_order_valid,
   input  logic         i_order_ready,
   output logic [27:0]  o_order_data,
   output logic         o_busy,
   output logic [15:0]  o_order_count,
   output logic [15:0]  o_drop_count
);

   localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned COOL_W = $clog2(COOLDOWN_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES);
   localparam logic [COOL_W-1:0] COOL_ONE  = 1;
   localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_CYCLES - 1);

   logic [1:0]          r_act_a, r_act_b, r_act_c;
   logic [15:0]         r_price_a, r_price_b, r_price_c;
   logic [1:0]          r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [COOL_W-1:0]   r_cool, w_cool_nxt;
   logic [EX_W-1:0]     r_buy_ex, w_buy_ex_nxt;
   logic [EX_W-1:0]     r_sell_ex, w_sell_ex_nxt;
   logic [SEQ_W-1:0]    r_seq;
   logic [15:0]         r_order_count;
   logic [15:0]         r_drop_count;

   pattern_t            w_pat;
   logic                w_emit;
   logic [15:0]         w_buy_price, w_sell_price, w_spread;
   logic                w_spread_low, w_spread_ok;
   logic                w_push_req, w_push, w_drop, w_pop;
   logic                w_fifo_full, w_fifo_empty;
   logic [ORDER_W-1:0]  w_order;

   assign w_pat = decode_pattern({r_act_c, r_act_b, r_act_a});

   // Input stage: the FSM only ever sees registered actions and prices
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_act_a   <= ACT_HOLD;
         r_act_b   <= ACT_HOLD;
         r_act_c   <= ACT_HOLD;
         r_price_a <= '0;
         r_price_b <= '0;
         r_price_c <= '0;
      end else begin
         r_act_a   <= i_action_a;
         r_act_b   <= i_action_b;
         r_act_c   <= i_action_c;
         r_price_a <= i_price_a;
         r_price_b <= i_price_b;
         r_price_c <= i_price_c;
      end
   end

   // Next-state logic: qualify a stable pattern, emit once, then cool down
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_cool_nxt    = r_cool;
      w_buy_ex_nxt  = r_buy_ex;
      w_sell_ex_nxt = r_sell_ex;
      w_emit        = 1'b0;
      if (!i_enable) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
         w_cool_nxt  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pat.ok) begin
                  w_state_nxt   = ST_QUALIFY;
                  w_cnt_nxt     = CNT_ONE;
                  w_buy_ex_nxt  = w_pat.buy_ex;
                  w_sell_ex_nxt = w_pat.sell_ex;
               end
            end
            ST_QUALIFY: begin
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt = ST_EMIT;
               end else if (!w_pat.ok) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end else if (w_pat.buy_ex == r_buy_ex && w_pat.sell_ex == r_sell_ex) begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end else begin
                  // A different valid pattern restarts the stability count
                  w_cnt_nxt     = CNT_ONE;
                  w_buy_ex_nxt  = w_pat.buy_ex;
                  w_sell_ex_nxt = w_pat.sell_ex;
               end
            end
            ST_EMIT: begin
               w_emit      = 1'b1;
               w_state_nxt = ST_COOLDOWN;
               w_cnt_nxt   = '0;
               w_cool_nxt  = '0;
            end
            ST_COOLDOWN: begin
               if (r_cool == COOL_LAST) begin
                  w_state_nxt = ST_IDLE;
                  w_cool_nxt  = '0;
               end else begin
                  w_cool_nxt = r_cool + COOL_ONE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Spread from the registered prices of the captured exchanges
   always_comb begin
      w_buy_price  = r_price_a;
      w_sell_price = r_price_a;
      case (r_buy_ex)
         EX_B:    w_buy_price = r_price_b;
         EX_C:    w_buy_price = r_price_c;
         default: w_buy_price = r_price_a;
      endcase
      case (r_sell_ex)
         EX_B:    w_sell_price = r_price_b;
         EX_C:    w_sell_price = r_price_c;
         default: w_sell_price = r_price_a;
      endcase
   end

   assign w_spread     = (w_sell_price >= w_buy_price) ? (w_sell_price - w_buy_price) : '0;
   assign w_spread_low = (w_spread < MIN_SPREAD);

`ifdef ORDER_SPREAD_CHECK_EN
   assign w_spread_ok = !w_spread_low;
`else
   // Threshold has no effect in this build
   logic w_unused_spread_low;
   assign w_unused_spread_low = w_spread_low;
   assign w_spread_ok = 1'b1;
`endif

   assign w_pop      = o_order_valid && i_order_ready;
   assign w_push_req = w_emit && w_spread_ok;
   assign w_push     = w_push_req && (!w_fifo_full || w_pop);
   assign w_drop     = w_push_req && w_fifo_full && !w_pop;

   // Assemble the order record from the package field layout
   always_comb begin
      w_order                           = '0;
      w_order[SEQ_LSB +: SEQ_W]         = r_seq;
      w_order[BUY_LSB +: EX_W]          = r_buy_ex;
      w_order[SELL_LSB +: EX_W]         = r_sell_ex;
      w_order[SPREAD_LSB +: SPREAD_W]   = w_spread;
   end

   // FSM, sequence number and saturating statistics
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_cool        <= '0;
         r_buy_ex      <= EX_A;
         r_sell_ex     <= EX_A;
         r_seq         <= '0;
         r_order_count <= '0;
         r_drop_count  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_cool    <= w_cool_nxt;
         r_buy_ex  <= w_buy_ex_nxt;
         r_sell_ex <= w_sell_ex_nxt;
         if (w_push) r_seq <= r_seq + 8'd1;
         if (w_pop && r_order_count != 16'hFFFF) r_order_count <= r_order_count + 16'd1;
         if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
   end

   order_fifo #(
      .WIDTH (ORDER_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_push    (w_push),
      .i_data    (w_order),
      .i_pop     (w_pop),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty),
      .o_data    (o_order_data)
   );

   assign o_order_valid = !w_fifo_empty;
   assign o_busy        = (r_state != ST_IDLE);
   assign o_order_count = r_order_count;
   assign o_drop_count  = r_drop_count;

endmodule

// File: tb/tb_arb_order_sequencer.sv
// Self-checking bench for arb_order_sequencer: table of single-pattern vectors,
// hand-written multi-cycle sequences, and randomized traffic against a
// behavioural reference model.
module tb_arb_order_sequencer;

   localparam int unsigned STABLE = 4;
   localparam int unsigned COOL   = 1;
   localparam int unsigned DEPTH  = 4;
   localparam int          MINSP  = 50;
`ifdef ORDER_SPREAD_CHECK_EN
   localparam bit SPREAD_CHK = 1'b1;
`else
   localparam bit SPREAD_CHK = 1'b0;
`endif

   localparam logic [1:0] HOLD = 2'b00, BUY = 2'b01, SELL = 2'b10, NONE = 2'b11;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b1;
   logic [15:0] pa = '0, pb = '0, pc = '0;
   logic [1:0]  aa = NONE, ab = NONE, ac = NONE;
   logic        ready = 1'b1;
   logic        valid;
   logic [27:0] data;
   logic        busy;
   logic [15:0] ocnt, dcnt;

   always #10 clk = ~clk;

   arb_order_sequencer #(
      .STABLE_CYCLES   (STABLE),
      .COOLDOWN_CYCLES (COOL),
      .FIFO_DEPTH      (DEPTH),
      .MIN_SPREAD      (16'd50)
   ) dut (
      .i_clk         (clk),
      .i_reset_n     (reset_n),
      .i_enable      (enable),
      .i_price_a     (pa),
      .i_price_b     (pb),
      .i_price_c     (pc),
      .i_action_a    (aa),
      .i_action_b    (ab),
      .i_action_c    (ac),
      .o_order_valid (valid),
      .i_order_ready (ready),
      .o_order_data  (data),
      .o_busy        (busy),
      .o_order_count (ocnt),
      .o_drop_count  (dcnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Registered view of the inputs, then a run-length / countdown description
   // of the qualification and cooldown behaviour.
   logic [1:0]  m_act [3];
   logic [15:0] m_price [3];
   int          m_run;       // consecutive identical valid patterns (0 = idle)
   int          m_buy, m_sell;
   bit          m_emit;
   int          m_cool;      // cooldown cycles left
   logic [27:0] m_q [$];
   int          m_seq, m_ocnt, m_dcnt;

   // DUT head as seen at the previous falling edge, and the log of handshakes
   bit          s_valid;
   logic [27:0] s_data;
   logic [27:0] pop_log [$];

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_act[i]   = HOLD;
         m_price[i] = '0;
      end
      m_run = 0; m_buy = 0; m_sell = 0; m_emit = 0; m_cool = 0;
      m_q.delete();
      m_seq = 0; m_ocnt = 0; m_dcnt = 0;
      s_valid = 0; s_data = '0;
   endtask

   function automatic bit m_decode(output int buy, output int sell);
      int nb = 0, ns = 0, nh = 0;
      buy = 0; sell = 0;
      for (int i = 0; i < 3; i++) begin
         if (m_act[i] == BUY) begin nb++; buy = i; end
         else if (m_act[i] == SELL) begin ns++; sell = i; end
         else if (m_act[i] == HOLD) nh++;
      end
      return (nb == 1) && (ns == 1) && (nh == 1);
   endfunction

   task automatic model_edge();
      bit          pop, vld, push;
      int          b, s, sp;
      logic [27:0] rec;
      pop  = (m_q.size() > 0) && ready;
      push = 0;
      rec  = '0;
      vld  = m_decode(b, s);
      if (ready && s_valid) pop_log.push_back(s_data);
      if (pop && m_ocnt < 65535) m_ocnt++;
      if (!enable) begin
         m_run = 0; m_emit = 0; m_cool = 0;
      end else if (m_emit) begin
         sp = int'(m_price[m_sell]) - int'(m_price[m_buy]);
         if (sp < 0) sp = 0;
         m_emit = 0;
         m_cool = COOL;
         if (!SPREAD_CHK || sp >= MINSP) begin
            if (m_q.size() < DEPTH || pop) begin
               push  = 1;
               rec   = {8'(m_seq), 2'(m_buy), 2'(m_sell), 16'(sp)};
               m_seq = (m_seq + 1) % 256;
            end else if (m_dcnt < 65535) begin
               m_dcnt++;
            end
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else if (m_run == STABLE) begin
         m_run  = 0;
         m_emit = 1;
      end else if (m_run > 0) begin
         if (!vld) m_run = 0;
         else if (b == m_buy && s == m_sell) m_run++;
         else begin m_run = 1; m_buy = b; m_sell = s; end
      end else if (vld) begin
         m_run = 1; m_buy = b; m_sell = s;
      end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(rec);
      m_act[0] = aa; m_act[1] = ab; m_act[2] = ac;
      m_price[0] = pa; m_price[1] = pb; m_price[2] = pc;
   endtask

   // One clock: model follows the rising edge, outputs compared on the falling edge
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("valid", valid, (m_q.size() != 0));
      check("busy", busy, (m_run > 0) || m_emit || (m_cool > 0));
      check("order_count", ocnt, m_ocnt);
      check("drop_count", dcnt, m_dcnt);
      if (m_q.size() != 0) check("head", data, m_q[0]);
      s_valid = valid;
      s_data  = data;
   endtask

   task automatic set_acts(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
      aa = a; ab = b; ac = c;
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_valid"}, valid, 0);
      check({tag, "_data"}, data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_ocnt"}, ocnt, 0);
      check({tag, "_dcnt"}, dcnt, 0);
   endtask

   task automatic do_reset();
      reset_n = 0;
      enable  = 1;
      ready   = 1;
      set_acts(NONE, NONE, NONE);
      pa = '0; pb = '0; pc = '0;
      model_reset();
      pop_log.delete();
      repeat (2) @(negedge clk);
      reset_n = 1;
   endtask

   typedef struct {
      logic [1:0]  a, b, c;
      logic [15:0] pa, pb, pc;
      bit          ok;
      logic [1:0]  buy, sell;
      logic [15:0] spread;
   } vec_t;

   vec_t        tbl [9];
   int          exp_seq;
   bit          exp_push;
   logic [27:0] rec;
   int          hold, bi, si;
   logic [1:0]  ra [3];

   initial begin
      tbl[0] = '{SELL, HOLD, BUY,  16'd300,   16'd200, 16'd100, 1'b1, 2'd2, 2'd0, 16'd200};
      tbl[1] = '{BUY,  SELL, HOLD, 16'd100,   16'd150, 16'd9,   1'b1, 2'd0, 2'd1, 16'd50};
      tbl[2] = '{HOLD, BUY,  SELL, 16'd7,     16'd500, 16'd100, 1'b1, 2'd1, 2'd2, 16'd0};
      tbl[3] = '{BUY,  BUY,  SELL, 16'd1,     16'd2,   16'd300, 1'b0, 2'd0, 2'd0, 16'd0};
      tbl[4] = '{NONE, SELL, BUY,  16'd1,     16'd900, 16'd3,   1'b0, 2'd0, 2'd0, 16'd0};
      tbl[5] = '{HOLD, HOLD, HOLD, 16'd5,     16'd6,   16'd7,   1'b0, 2'd0, 2'd0, 16'd0};
      tbl[6] = '{SELL, HOLD, BUY,  16'd120,   16'd0,   16'd100, 1'b1, 2'd2, 2'd0, 16'd20};
      tbl[7] = '{HOLD, SELL, BUY,  16'd4,     16'd1000, 16'd940, 1'b1, 2'd2, 2'd1, 16'd60};
      tbl[8] = '{SELL, BUY,  HOLD, 16'd65535, 16'd0,   16'd77,  1'b1, 2'd1, 2'd0, 16'd65535};

      // ---- reset values ----
      do_reset();
      reset_checks("reset");

      // ---- first-order latency: pattern before edge 0, valid after edge 6 ----
      set_acts(SELL, HOLD, BUY);
      pa = 16'd300; pb = 16'd200; pc = 16'd100;
      for (int e = 0; e < 10; e++) begin
         step();
         if (e == 5) check("lat_before_edge6", valid, 0);
         if (e == 6) begin
            check("lat_valid_edge6", valid, 1);
            check("lat_order", data, {8'd0, 2'd2, 2'd0, 16'd200});
         end
         if (e == 7) check("lat_drained", valid, 0);
      end
      set_acts(NONE, NONE, NONE);
      repeat (4) step();
      check("lat_one_order", pop_log.size(), 1);

      // ---- table of single patterns ----
      do_reset();
      exp_seq = 0;
      for (int i = 0; i < 9; i++) begin
         pop_log.delete();
         set_acts(tbl[i].a, tbl[i].b, tbl[i].c);
         pa = tbl[i].pa; pb = tbl[i].pb; pc = tbl[i].pc;
         repeat (7) step();
         set_acts(NONE, NONE, NONE);
         repeat (6) step();
         exp_push = tbl[i].ok && (!SPREAD_CHK || tbl[i].spread >= 16'(MINSP));
         check($sformatf("tbl%0d_orders", i), pop_log.size(), exp_push ? 1 : 0);
         if (exp_push && pop_log.size() > 0) begin
            rec = pop_log[0];
            check($sformatf("tbl%0d_seq", i), rec[27:20], exp_seq);
            check($sformatf("tbl%0d_buy", i), rec[19:18], tbl[i].buy);
            check($sformatf("tbl%0d_sell", i), rec[17:16], tbl[i].sell);
            check($sformatf("tbl%0d_spread", i), rec[15:0], tbl[i].spread);
            exp_seq++;
         end
         check($sformatf("tbl%0d_idle", i), busy, 0);
      end

      // ---- pattern held 3 cycles then NONE: no order, back to idle ----
      do_reset();
      set_acts(BUY, HOLD, SELL);
      pa = 16'd10; pb = 16'd20; pc = 16'd90;
      repeat (3) step();
      set_acts(NONE, NONE, NONE);
      step();
      check("short_busy_mid", busy, 1);
      repeat (6) step();
      check("short_no_order", pop_log.size(), 0);
      check("short_idle", busy, 0);

      // ---- pattern change at cnt=2 restarts; order carries second pattern ----
      do_reset();
      set_acts(SELL, HOLD, BUY);
      pa = 16'd300; pb = 16'd200; pc = 16'd100;
      repeat (2) step();
      set_acts(HOLD, SELL, BUY);
      step();
      step();
      check("restart_busy", busy, 1);
      repeat (5) step();
      set_acts(NONE, NONE, NONE);
      repeat (6) step();
      check("restart_orders", pop_log.size(), 1);
      if (pop_log.size() > 0) begin
         rec = pop_log[0];
         check("restart_buy", rec[19:18], 2);
         check("restart_sell", rec[17:16], 1);
         check("restart_spread", rec[15:0], 100);
      end

      // ---- backpressure: 6 qualifications, 4 queued, 2 dropped, then drain ----
      do_reset();
      ready = 0;
      set_acts(BUY, SELL, HOLD);
      pa = 16'd100; pb = 16'd400; pc = 16'd0;
      repeat (42) step();
      set_acts(NONE, NONE, NONE);
      repeat (3) step();
      check("bp_drops", dcnt, 2);
      check("bp_valid", valid, 1);
      check("bp_ocnt0", ocnt, 0);
      ready = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("bp_valid_after_pop%0d", k), valid, (k < 3) ? 1 : 0);
      end
      check("bp_pops", pop_log.size(), 4);
      for (int k = 0; k < 4 && k < pop_log.size(); k++) begin
         rec = pop_log[k];
         check($sformatf("bp_seq%0d", k), rec[27:20], k);
      end
      check("bp_ocnt", ocnt, 4);

      // ---- enable dropped during qualification: no order ----
      do_reset();
      set_acts(HOLD, BUY, SELL);
      pa = 16'd0; pb = 16'd5; pc = 16'd300;
      repeat (3) step();
      enable = 0;
      step();
      check("en_abort_busy", busy, 0);
      step();
      enable = 1;
      set_acts(NONE, NONE, NONE);
      repeat (8) step();
      check("en_no_order", pop_log.size(), 0);
      check("en_idle", busy, 0);

      // ---- asynchronous reset with two queued orders ----
      do_reset();
      ready = 0;
      set_acts(SELL, BUY, HOLD);
      pa = 16'd900; pb = 16'd100; pc = 16'd0;
      repeat (14) step();
      set_acts(NONE, NONE, NONE);
      repeat (3) step();
      check("rst_q_valid", valid, 1);
      check("rst_q_busy", busy, 0);
      reset_n = 0;
      #1;
      reset_checks("midrst");
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1;
      ready = 1;
      repeat (3) step();
      check("midrst_stay_empty", valid, 0);

      // ---- randomized traffic against the model ----
      do_reset();
      hold = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (hold == 0) begin
            hold = int'($urandom_range(1, 12));
            if ($urandom_range(0, 9) < 7) begin
               bi = int'($urandom_range(0, 2));
               si = (bi + 1 + int'($urandom_range(0, 1))) % 3;
               for (int j = 0; j < 3; j++) ra[j] = HOLD;
               ra[bi] = BUY;
               ra[si] = SELL;
            end else begin
               for (int j = 0; j < 3; j++) ra[j] = 2'($urandom_range(0, 3));
            end
            set_acts(ra[0], ra[1], ra[2]);
            if ($urandom_range(0, 1) == 0) begin
               pa = 16'($urandom_range(0, 200));
               pb = 16'($urandom_range(0, 200));
               pc = 16'($urandom_range(0, 200));
            end else begin
               pa = 16'($urandom_range(0, 65535));
               pb = 16'($urandom_range(0, 65535));
               pc = 16'($urandom_range(0, 65535));
            end
         end
         hold--;
         ready  = ($urandom_range(0, 3) != 0);
         enable = ($urandom_range(0, 49) != 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
